// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter and its store buffer.
package dmem_arb_pkg;

  localparam int DEF_TAG_W = 6;

  // Store size encodings; zero means a full word.
  localparam logic [1:0] SZ_WORD = 2'd0;
  localparam logic [1:0] SZ_BYTE = 2'd1;
  localparam logic [1:0] SZ_HALF = 2'd2;
  localparam logic [1:0] SZ_TRI  = 2'd3;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    DONE
  } arb_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
  } sb_entry_t;

endpackage

// File: rtl/store_buffer.sv
// In-order circular buffer of committed stores with a word-address match
// against every occupied entry.
module store_buffer
  import dmem_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  sb_entry_t              push_entry,
  input  logic                   pop,
  input  logic [29:0]            match_word,
  output sb_entry_t              head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   hit
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  sb_entry_t        mem_q [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;

  always_comb begin
    valid_d = valid_q;
    if (pop)  valid_d[rd_ptr_q] = 1'b0;
    if (push) valid_d[wr_ptr_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
      valid_q <= valid_d;
    end
  end

  // Payload needs no reset: the valid bits and count gate every use of it.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_entry;
  end

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (mem_q[i].addr[31:2] == match_word)) hit = 1'b1;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single data-memory port between speculative loads and buffered
// committed stores, and drains the buffer before a syscall may proceed.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = DEF_TAG_W
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [31:0]      ld_addr,
  input  logic [TAG_W-1:0] ld_tag,
  output logic             ld_resp_valid,
  output logic [TAG_W-1:0] ld_resp_tag,
  output logic [31:0]      ld_resp_data,
  input  logic             st_valid,
  output logic             st_ready,
  input  logic [31:0]      st_addr,
  input  logic [31:0]      st_data,
  input  logic [1:0]       st_size,
  input  logic             flush,
  input  logic             sys_req,
  output logic             sys_ready,
  output logic [31:0]      mem_addr,
  output logic             mem_read,
  output logic             mem_write,
  output logic [31:0]      mem_wdata,
  output logic [1:0]       mem_wsize,
  input  logic [31:0]      mem_rdata
);

  localparam int CW = $clog2(DEPTH) + 1;

  arb_state_e       state_q, state_d;
  logic             resp_pend_q;
  logic [TAG_W-1:0] resp_tag_q;
  logic [31:0]      resp_data_q;
  logic             sys_ready_q;

  sb_entry_t     sb_head, st_entry;
  logic          sb_full, sb_empty, sb_hit;
  logic [CW-1:0] sb_count, count_next;
  logic          st_push, ld_grant, st_grant;

  // Handshakes: a store transfers when st_valid && st_ready (st_ready depends
  // only on buffer occupancy); a load transfers when ld_valid && ld_ready, and
  // ld_ready is the load grant itself, so it may depend on ld_valid/ld_addr.
  assign st_ready = !sb_full;
  assign st_push  = st_valid && !sb_full;
  assign st_entry = '{addr: st_addr, data: st_data, size: st_size};

  store_buffer #(.DEPTH(DEPTH)) u_sb (
    .clk        (CLK),
    .rst_n      (RESET),
    .push       (st_push),
    .push_entry (st_entry),
    .pop        (st_grant),
    .match_word (ld_addr[31:2]),
    .head       (sb_head),
    .full       (sb_full),
    .empty      (sb_empty),
    .count      (sb_count),
    .hit        (sb_hit)
  );

  assign count_next = sb_count + CW'(st_push) - CW'(st_grant);

  always_comb begin
    state_d  = state_q;
    ld_grant = 1'b0;
    st_grant = 1'b0;
    unique case (state_q)
      RUN: begin
        if (sb_full)                              st_grant = 1'b1;
        else if (ld_valid && !sb_hit && !flush)   ld_grant = 1'b1;
        else if (!sb_empty)                       st_grant = 1'b1;
        if (sys_req) state_d = DRAIN;
      end
      DRAIN: begin
        st_grant = !sb_empty;
        // Leave once this cycle's write empties the buffer and no load is in flight.
        if (count_next == '0 && !resp_pend_q) state_d = DONE;
      end
      DONE: begin
        if (!sys_req) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  assign ld_ready  = ld_grant;
  assign mem_read  = ld_grant;
  assign mem_write = st_grant;
  assign mem_addr  = ld_grant ? ld_addr : (st_grant ? sb_head.addr : 32'h0);
  assign mem_wdata = st_grant ? sb_head.data : 32'h0;
  assign mem_wsize = st_grant ? sb_head.size : 2'd0;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= RUN;
      resp_pend_q <= 1'b0;
      resp_tag_q  <= '0;
      resp_data_q <= '0;
      sys_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      resp_pend_q <= ld_grant;
      sys_ready_q <= (state_d == DONE);
      if (ld_grant) begin
        resp_tag_q  <= ld_tag;
        resp_data_q <= mem_rdata;
      end
    end
  end

  // A flush in the response cycle squashes the returning load.
  assign ld_resp_valid = resp_pend_q && !flush;
  assign ld_resp_tag   = resp_tag_q;
  assign ld_resp_data  = resp_data_q;
  assign sys_ready     = sys_ready_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: inputs change 1 time unit after the
// rising edge, outputs are compared 2 units later, mid-cycle.
module tb_dmem_port_arbiter;

  localparam int TAG_W = 6;

  logic             CLK = 1'b0;
  logic             RESET;
  logic             ld_valid, ld_ready;
  logic [31:0]      ld_addr;
  logic [TAG_W-1:0] ld_tag;
  logic             ld_resp_valid;
  logic [TAG_W-1:0] ld_resp_tag;
  logic [31:0]      ld_resp_data;
  logic             st_valid, st_ready;
  logic [31:0]      st_addr, st_data;
  logic [1:0]       st_size;
  logic             flush, sys_req, sys_ready;
  logic [31:0]      mem_addr;
  logic             mem_read, mem_write;
  logic [31:0]      mem_wdata;
  logic [1:0]       mem_wsize;
  logic [31:0]      mem_rdata;

  int vecs = 0;
  int errs = 0;

  dmem_port_arbiter #(.DEPTH(4), .TAG_W(TAG_W)) dut (
    .CLK(CLK), .RESET(RESET),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_tag(ld_tag),
    .ld_resp_valid(ld_resp_valid), .ld_resp_tag(ld_resp_tag), .ld_resp_data(ld_resp_data),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data),
    .st_size(st_size), .flush(flush), .sys_req(sys_req), .sys_ready(sys_ready),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_wsize(mem_wsize), .mem_rdata(mem_rdata)
  );

  always #5 CLK = ~CLK;

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    ld_valid = 0; ld_addr = 0; ld_tag = 0; st_valid = 0; st_addr = 0; st_data = 0;
    st_size = 0; flush = 0; sys_req = 0; mem_rdata = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    RESET = 0;
    #3;
    vecs++; if (st_ready !== 1'b1) begin errs++; $display("FAIL rst_st_ready: got %b exp 1", st_ready); end
    vecs++; if ({mem_read, mem_write} !== 2'b00) begin errs++; $display("FAIL rst_strobes: got %b exp 00", {mem_read, mem_write}); end
    vecs++; if ({ld_resp_valid, sys_ready, ld_ready} !== 3'b000) begin errs++; $display("FAIL rst_flags: got %b exp 000", {ld_resp_valid, sys_ready, ld_ready}); end
    vecs++; if (ld_resp_tag !== 6'd0 || ld_resp_data !== 32'h0) begin errs++; $display("FAIL rst_resp: got %h/%h exp 0/0", ld_resp_tag, ld_resp_data); end
    vecs++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_wsize !== 2'd0) begin errs++; $display("FAIL rst_bus: got %h/%h/%h exp 0", mem_addr, mem_wdata, mem_wsize); end
    cyc(); cyc();
    RESET = 1;
    for (int i = 0; i < 5; i++) begin
      #2;
      vecs++; if ({mem_read, mem_write} !== 2'b00) begin errs++; $display("FAIL idle_strobes[%0d]: got %b exp 00", i, {mem_read, mem_write}); end
      cyc();
    end
  endtask

  task automatic test_load();
    ld_valid = 1; ld_addr = 32'h100; ld_tag = 5; mem_rdata = 32'hDEADBEEF;
    #2;
    vecs++; if (mem_read !== 1'b1 || mem_addr !== 32'h100) begin errs++; $display("FAIL ld_issue: got rd=%b addr=%h exp rd=1 addr=100", mem_read, mem_addr); end
    vecs++; if (ld_ready !== 1'b1 || mem_write !== 1'b0) begin errs++; $display("FAIL ld_ready: got rdy=%b wr=%b exp 1/0", ld_ready, mem_write); end
    cyc();
    ld_valid = 0; ld_addr = 0; ld_tag = 0; mem_rdata = 0;
    #2;
    vecs++; if ({ld_resp_valid, ld_resp_tag, ld_resp_data} !== {1'b1, 6'd5, 32'hDEADBEEF}) begin errs++; $display("FAIL ld_resp: got v=%b tag=%0d data=%h exp 1/5/deadbeef", ld_resp_valid, ld_resp_tag, ld_resp_data); end
    cyc();
    ld_valid = 1; ld_addr = 32'h104; ld_tag = 1; mem_rdata = 32'hA1;
    #2;
    vecs++; if (ld_ready !== 1'b1) begin errs++; $display("FAIL b2b_grant0: got %b exp 1", ld_ready); end
    cyc();
    ld_addr = 32'h108; ld_tag = 2; mem_rdata = 32'hB2;
    #2;
    vecs++; if (ld_ready !== 1'b1) begin errs++; $display("FAIL b2b_grant1: got %b exp 1", ld_ready); end
    vecs++; if ({ld_resp_valid, ld_resp_tag, ld_resp_data} !== {1'b1, 6'd1, 32'hA1}) begin errs++; $display("FAIL b2b_resp0: got v=%b tag=%0d data=%h exp 1/1/a1", ld_resp_valid, ld_resp_tag, ld_resp_data); end
    cyc();
    ld_valid = 0;
    #2;
    vecs++; if ({ld_resp_valid, ld_resp_tag, ld_resp_data} !== {1'b1, 6'd2, 32'hB2}) begin errs++; $display("FAIL b2b_resp1: got v=%b tag=%0d data=%h exp 1/2/b2", ld_resp_valid, ld_resp_tag, ld_resp_data); end
    cyc();
    #2;
    vecs++; if (ld_resp_valid !== 1'b0) begin errs++; $display("FAIL resp_idle: got %b exp 0", ld_resp_valid); end
    cyc();
  endtask

  task automatic test_alias();
    st_valid = 1; st_addr = 32'h200; st_data = 32'h11; st_size = 2'd2;
    ld_valid = 1; ld_addr = 32'h200; ld_tag = 3; mem_rdata = 32'h55;
    #2;
    vecs++; if (ld_ready !== 1'b1 || mem_write !== 1'b0) begin errs++; $display("FAIL same_cycle_enq: got rdy=%b wr=%b exp 1/0", ld_ready, mem_write); end
    cyc();
    st_valid = 0; ld_addr = 32'h202; ld_tag = 4;
    #2;
    vecs++; if (ld_ready !== 1'b0) begin errs++; $display("FAIL alias_hold: got %b exp 0", ld_ready); end
    vecs++; if ({mem_write, mem_addr, mem_wdata, mem_wsize} !== {1'b1, 32'h200, 32'h11, 2'd2}) begin errs++; $display("FAIL alias_write: got wr=%b addr=%h data=%h sz=%0d exp 1/200/11/2", mem_write, mem_addr, mem_wdata, mem_wsize); end
    cyc();
    #2;
    vecs++; if ({ld_ready, mem_read, mem_addr} !== {2'b11, 32'h202}) begin errs++; $display("FAIL alias_release: got rdy=%b rd=%b addr=%h exp 1/1/202", ld_ready, mem_read, mem_addr); end
    cyc();
    idle_inputs();
    cyc();
  endtask

  task automatic test_full();
    ld_valid = 1; ld_addr = 32'h400; ld_tag = 1;
    for (int i = 0; i < 4; i++) begin
      st_valid = 1; st_addr = 32'h500 + 32'(4 * i); st_data = 32'h20 + 32'(i);
      #2;
      vecs++; if ({ld_ready, st_ready, mem_write} !== 3'b110) begin errs++; $display("FAIL fill[%0d]: got rdy/st_rdy/wr=%b exp 110", i, {ld_ready, st_ready, mem_write}); end
      cyc();
    end
    st_addr = 32'h510; st_data = 32'hFF;
    #2;
    vecs++; if (st_ready !== 1'b0 || ld_ready !== 1'b0) begin errs++; $display("FAIL full_ready: got st=%b ld=%b exp 0/0", st_ready, ld_ready); end
    vecs++; if (mem_write !== 1'b1 || mem_addr !== 32'h500) begin errs++; $display("FAIL full_head: got wr=%b addr=%h exp 1/500", mem_write, mem_addr); end
    cyc();
    st_valid = 0;
    #2;
    vecs++; if ({ld_ready, st_ready} !== 2'b11) begin errs++; $display("FAIL full_resume: got ld/st=%b exp 11", {ld_ready, st_ready}); end
    cyc();
    ld_valid = 0;
    for (int i = 1; i < 4; i++) begin
      #2;
      vecs++; if ({mem_write, mem_addr, mem_wdata} !== {1'b1, 32'h500 + 32'(4 * i), 32'h20 + 32'(i)}) begin errs++; $display("FAIL fifo_order[%0d]: got wr=%b addr=%h data=%h", i, mem_write, mem_addr, mem_wdata); end
      cyc();
    end
    #2;
    vecs++; if (mem_write !== 1'b0) begin errs++; $display("FAIL fifo_empty: got %b exp 0", mem_write); end
    cyc();
  endtask

  task automatic test_drain();
    ld_valid = 1; ld_addr = 32'h700; ld_tag = 2;
    for (int i = 0; i < 3; i++) begin
      st_valid = 1; st_addr = 32'h600 + 32'(4 * i); st_data = 32'h30 + 32'(i);
      cyc();
    end
    st_valid = 0; ld_valid = 0; sys_req = 1;
    #2;
    vecs++; if ({mem_write, mem_read, mem_addr} !== {2'b10, 32'h600}) begin errs++; $display("FAIL drain_w0: got wr=%b rd=%b addr=%h exp 1/0/600", mem_write, mem_read, mem_addr); end
    cyc();
    ld_valid = 1;
    for (int i = 1; i < 3; i++) begin
      #2;
      vecs++; if ({mem_write, mem_read, sys_ready, mem_addr} !== {3'b100, 32'h600 + 32'(4 * i)}) begin errs++; $display("FAIL drain_w%0d: got wr=%b rd=%b sys=%b addr=%h", i, mem_write, mem_read, sys_ready, mem_addr); end
      cyc();
    end
    #2;
    vecs++; if ({sys_ready, mem_read, mem_write, ld_ready} !== 4'b1000) begin errs++; $display("FAIL drain_done: got sys/rd/wr/rdy=%b exp 1000", {sys_ready, mem_read, mem_write, ld_ready}); end
    cyc();
    sys_req = 0;
    #2;
    vecs++; if ({sys_ready, ld_ready} !== 2'b10) begin errs++; $display("FAIL done_hold: got sys/rdy=%b exp 10", {sys_ready, ld_ready}); end
    cyc();
    #2;
    vecs++; if ({sys_ready, ld_ready, mem_read} !== 3'b011) begin errs++; $display("FAIL run_again: got sys/rdy/rd=%b exp 011", {sys_ready, ld_ready, mem_read}); end
    cyc();
    idle_inputs();
    cyc();
  endtask

  task automatic test_flush();
    ld_valid = 1; ld_addr = 32'h800; ld_tag = 9; mem_rdata = 32'h99;
    st_valid = 1; st_addr = 32'h900; st_data = 32'h77;
    #2;
    vecs++; if (ld_ready !== 1'b1) begin errs++; $display("FAIL flush_ld_grant: got %b exp 1", ld_ready); end
    cyc();
    st_valid = 0; flush = 1; ld_addr = 32'h804; ld_tag = 10;
    #2;
    vecs++; if (ld_resp_valid !== 1'b0) begin errs++; $display("FAIL flush_resp: got %b exp 0", ld_resp_valid); end
    vecs++; if ({ld_ready, mem_read} !== 2'b00) begin errs++; $display("FAIL flush_block: got rdy/rd=%b exp 00", {ld_ready, mem_read}); end
    vecs++; if (mem_write !== 1'b1 || mem_addr !== 32'h900) begin errs++; $display("FAIL flush_store: got wr=%b addr=%h exp 1/900", mem_write, mem_addr); end
    cyc();
    flush = 0; ld_valid = 0;
    #2;
    vecs++; if (ld_resp_valid !== 1'b0) begin errs++; $display("FAIL flush_after: got %b exp 0", ld_resp_valid); end
    cyc();
  endtask

  task automatic test_reset_mid_drain();
    ld_valid = 1; ld_addr = 32'hA00;
    for (int i = 0; i < 3; i++) begin
      st_valid = 1; st_addr = 32'hB00 + 32'(4 * i); st_data = 32'h40 + 32'(i);
      cyc();
    end
    st_valid = 0; ld_valid = 0; sys_req = 1;
    cyc();
    #2;
    RESET = 0;
    #1;
    vecs++; if ({mem_write, st_ready, sys_ready} !== 3'b010) begin errs++; $display("FAIL mid_rst: got wr/st_rdy/sys=%b exp 010", {mem_write, st_ready, sys_ready}); end
    sys_req = 0;
    cyc(); cyc();
    RESET = 1;
    for (int i = 0; i < 3; i++) begin
      #2;
      vecs++; if ({mem_write, st_ready} !== 2'b01) begin errs++; $display("FAIL post_rst[%0d]: got wr/st_rdy=%b exp 01", i, {mem_write, st_ready}); end
      cyc();
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_alias();
    test_full();
    test_drain();
    test_flush();
    test_reset_mid_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
